// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared channel state and counter sizing for the input conditioner
package input_cond_pkg;
  typedef enum logic {ST_STABLE, ST_PENDING} ch_state_t;
  function automatic int cnt_w(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one pin through a 2-FF synchroniser, then a tick-sampled stability FSM
module debounce_ch
  import input_cond_pkg::*;
#(
  parameter int STABLE_TICKS = 8
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o
);
  localparam int CW = cnt_w(STABLE_TICKS);
  logic [1:0] sync;
  logic s, diff, last, d_n;
  ch_state_t state, state_n;
  logic [CW-1:0] c, c_n;
  assign s = sync[1];
  assign diff = s != level_o;
  assign last = int'(c) + 1 == STABLE_TICKS;
  // synchroniser, FSM state, stability counter and debounced level
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      sync <= '0;
      state <= ST_STABLE;
      c <= '0;
      level_o <= 1'b0;
    end else begin
      sync <= {sync[0], raw_i};
      state <= state_n;
      c <= c_n;
      level_o <= d_n;
    end
  // flip only after STABLE_TICKS consecutive ticks disagree with the held level
  always_comb begin
    state_n = state;
    c_n = c;
    d_n = level_o;
    if (tick_i && state == ST_STABLE && diff) begin
      if (STABLE_TICKS == 1) d_n = ~level_o;
      else begin
        state_n = ST_PENDING;
        c_n = CW'(1);
      end
    end else if (tick_i && state == ST_PENDING) begin
      if (!diff) begin
        state_n = ST_STABLE;
        c_n = '0;
      end else if (last) begin
        d_n = ~level_o;
        state_n = ST_STABLE;
        c_n = '0;
      end else c_n = c + 1'b1;
    end
  end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounced button/switch levels plus a button press pulse
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int SW_WIDTH     = 16,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 8
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                btn_i,
  input  logic [SW_WIDTH-1:0] sw_i,
  output logic                btn_o,
  output logic [SW_WIDTH-1:0] sw_o,
  output logic                irq_o
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] p;
  logic tick, btn_q;
  logic [SW_WIDTH:0] raw, lvl;
  assign tick = p == PW'(TICK_DIV - 1);
  assign raw = {btn_i, sw_i};
  assign sw_o = lvl[SW_WIDTH-1:0];
  assign btn_o = lvl[SW_WIDTH];
  assign irq_o = btn_o & ~btn_q;
  // shared prescaler; wraps the cycle after tick
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) p <= '0;
    else p <= tick ? '0 : p + 1'b1;
  // previous button level so the pulse coincides with the first cycle btn_o is high
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) btn_q <= 1'b0;
    else btn_q <= btn_o;
  for (genvar i = 0; i <= SW_WIDTH; i++) begin : g_ch
    debounce_ch #(.STABLE_TICKS(STABLE_TICKS)) u_ch (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .tick_i (tick),
      .raw_i  (raw[i]),
      .level_o(lvl[i])
    );
  end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed checks of debounce latency, glitch rejection, irq and reset
module tb_input_conditioner;
  logic clk = 1'b0, arst = 1'b1, btn = 1'b1;
  logic [15:0] sw = 16'hFFFF;
  logic btn_o, irq_o;
  logic [15:0] sw_o;
  int vectors = 0, errs = 0, irq_cnt = 0, falls = 0;
  logic prev_btn = 1'b0;
  int n, base, fbase, nz;
  logic irq_at;

  input_conditioner #(.SW_WIDTH(16), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
    .clk_i (clk),
    .arst_i(arst),
    .btn_i (btn),
    .sw_i  (sw),
    .btn_o (btn_o),
    .sw_o  (sw_o),
    .irq_o (irq_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (irq_o) irq_cnt <= irq_cnt + 1;
    if (prev_btn && !btn_o) falls <= falls + 1;
    prev_btn <= btn_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lat(input string tag, input int lat);
    vectors++;
    assert (lat >= 11 && lat <= 14) else begin
      errs++;
      $error("FAIL %s: observed latency %0d expected 11..14", tag, lat);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_btn(input logic v, output int cyc, output logic irq_seen);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (btn_o !== v && cyc < 40);
    irq_seen = irq_o;
  endtask

  task automatic wait_sw_change(input logic [15:0] from, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (sw_o === from && cyc < 40);
  endtask

  initial begin
    // 1: reset with all pins high, then release
    step(5);
    chk("rst_btn", btn_o, 0);
    chk("rst_sw", sw_o, 16'h0000);
    chk("rst_irq", irq_o, 0);
    arst = 1'b0;
    wait_btn(1'b1, n, irq_at);
    chk_lat("rel_lat", n);
    chk("rel_btn", btn_o, 1);
    chk("rel_sw", sw_o, 16'hFFFF);
    chk("rel_irq_same_cycle", irq_at, 1);
    step(3);
    chk("rel_irq_count", irq_cnt, 1);
    // 2: release, clean press, release
    btn = 1'b0;
    wait_btn(1'b0, n, irq_at);
    chk_lat("rls1_lat", n);
    chk("rls1_btn", btn_o, 0);
    base = irq_cnt;
    btn = 1'b1;
    wait_btn(1'b1, n, irq_at);
    chk_lat("press_lat", n);
    chk("press_irq_same_cycle", irq_at, 1);
    step(3);
    chk("press_irq_count", irq_cnt - base, 1);
    chk("press_irq_width", irq_o, 0);
    base = irq_cnt;
    btn = 1'b0;
    wait_btn(1'b0, n, irq_at);
    chk_lat("rls2_lat", n);
    step(3);
    chk("rls2_no_irq", irq_cnt - base, 0);
    // 3: bounce every 3 cycles, then hold high
    base = irq_cnt;
    fbase = falls;
    for (int i = 0; i < 13; i++) begin
      btn = ~btn;
      step(3);
    end
    chk("bounce_held_low", btn_o, 0);
    btn = 1'b1;
    wait_btn(1'b1, n, irq_at);
    chk("bounce_btn", btn_o, 1);
    step(20);
    chk("bounce_irq_count", irq_cnt - base, 1);
    chk("bounce_no_fall", falls - fbase, 0);
    // 4: short glitch on sw[5]
    sw = 16'h0000;
    wait_sw_change(16'hFFFF, n);
    chk_lat("sw_clear_lat", n);
    chk("sw_clear", sw_o, 16'h0000);
    sw = 16'h0020;
    step(6);
    sw = 16'h0000;
    nz = 0;
    for (int i = 0; i < 24; i++) begin
      step(1);
      if (sw_o !== 16'h0000) nz++;
    end
    chk("glitch_nonzero_cycles", nz, 0);
    // 5: simultaneous change on many channels
    sw = 16'hA5A5;
    wait_sw_change(16'h0000, n);
    chk_lat("simul_lat", n);
    chk("simul_sw", sw_o, 16'hA5A5);
    // 6: reset mid-count of a press
    btn = 1'b0;
    wait_btn(1'b0, n, irq_at);
    chk("mid_pre_btn", btn_o, 0);
    btn = 1'b1;
    step(9);
    chk("mid_no_early_flip", btn_o, 0);
    arst = 1'b1;
    step(1);
    chk("mid_rst_btn", btn_o, 0);
    chk("mid_rst_irq", irq_o, 0);
    chk("mid_rst_sw", sw_o, 16'h0000);
    arst = 1'b0;
    wait_btn(1'b1, n, irq_at);
    chk_lat("mid_restart_lat", n);
    chk("mid_restart_irq", irq_at, 1);
    chk("mid_restart_sw", sw_o, 16'hA5A5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
